// File: rtl/relu_backward_stream.sv
// Backward ReLU: captures a per-element derivative mask from the forward stream,
// then gates the upstream gradient stream with it through a 1-entry output register.
module relu_backward_stream #(
  parameter int channels  = 1,
  parameter int rows      = 1,
  parameter int cols      = 1,
  parameter int data_size = 8,
  localparam int N  = channels * rows * cols,
  localparam int CW = (N > 1) ? $clog2(N) : 1,
  localparam int AW = $clog2(N + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fwd_valid,
  output logic                        fwd_ready,
  input  logic signed [data_size-1:0] fwd_data,
  input  logic                        grad_in_valid,
  output logic                        grad_in_ready,
  input  logic signed [data_size-1:0] grad_in_data,
  output logic                        grad_out_valid,
  input  logic                        grad_out_ready,
  output logic signed [data_size-1:0] grad_out_data,
  output logic                        phase,
  output logic [AW-1:0]               active_count,
  output logic                        done
);
  typedef enum logic {CAPTURE = 1'b0, BACKWARD = 1'b1} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [N-1:0]  mask;
  logic [CW-1:0] fwd_cnt, grad_cnt, out_cnt;
  logic          all_in;
  logic          fwd_acc, gin_acc, gout_acc, pos;

  assign phase         = (state == BACKWARD);
  assign fwd_ready     = (state == CAPTURE);
  // all_in blocks a second tensor's gradients until the last output drains
  assign grad_in_ready = (state == BACKWARD) && !all_in && (!grad_out_valid || grad_out_ready);
  assign fwd_acc       = fwd_valid && fwd_ready;
  assign gin_acc       = grad_in_valid && grad_in_ready;
  assign gout_acc      = grad_out_valid && grad_out_ready;
  assign done          = gout_acc && (out_cnt == LAST);
  assign pos           = !fwd_data[data_size-1] && (|fwd_data);

  always_ff @(posedge clk) begin
    if (fwd_acc) mask[fwd_cnt] <= pos;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= CAPTURE;
      fwd_cnt        <= '0;
      grad_cnt       <= '0;
      out_cnt        <= '0;
      all_in         <= 1'b0;
      grad_out_valid <= 1'b0;
      grad_out_data  <= '0;
      active_count   <= '0;
    end else begin
      if (fwd_acc) begin
        active_count <= ((fwd_cnt == '0) ? '0 : active_count) + AW'(pos);
        if (fwd_cnt == LAST) begin
          fwd_cnt <= '0;
          state   <= BACKWARD;
        end else begin
          fwd_cnt <= fwd_cnt + 1'b1;
        end
      end
      if (gin_acc) begin
        grad_out_valid <= 1'b1;
        grad_out_data  <= mask[grad_cnt] ? grad_in_data : '0;
        if (grad_cnt == LAST) begin
          grad_cnt <= '0;
          all_in   <= 1'b1;
        end else begin
          grad_cnt <= grad_cnt + 1'b1;
        end
      end else if (gout_acc) begin
        grad_out_valid <= 1'b0;
      end
      if (gout_acc) begin
        if (out_cnt == LAST) begin
          out_cnt <= '0;
          all_in  <= 1'b0;
          state   <= CAPTURE;
        end else begin
          out_cnt <= out_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_relu_backward_stream.sv
// Randomized bench for relu_backward_stream: scoreboard model of the mask/gate
// behaviour plus literal expectations for the hand-worked tensors.
module tb_relu_backward_stream;
  localparam int DW = 8;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 fwd_valid, fwd_ready, grad_in_valid, grad_in_ready;
  logic                 grad_out_valid, grad_out_ready, phase, done;
  logic signed [DW-1:0] fwd_data, grad_in_data, grad_out_data;
  logic [2:0]           active_count;

  logic                 b_fv, b_fr, b_gv, b_gr, b_ov, b_or, b_phase, b_done;
  logic signed [DW-1:0] b_fd, b_gd, b_od;
  logic [1:0]           b_ac;

  relu_backward_stream #(.channels(1), .rows(2), .cols(2), .data_size(DW)) u0 (
    .clk(clk), .rst(rst),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
    .grad_in_valid(grad_in_valid), .grad_in_ready(grad_in_ready), .grad_in_data(grad_in_data),
    .grad_out_valid(grad_out_valid), .grad_out_ready(grad_out_ready), .grad_out_data(grad_out_data),
    .phase(phase), .active_count(active_count), .done(done));

  relu_backward_stream #(.channels(2), .rows(1), .cols(1), .data_size(DW)) u1 (
    .clk(clk), .rst(rst),
    .fwd_valid(b_fv), .fwd_ready(b_fr), .fwd_data(b_fd),
    .grad_in_valid(b_gv), .grad_in_ready(b_gr), .grad_in_data(b_gd),
    .grad_out_valid(b_ov), .grad_out_ready(b_or), .grad_out_data(b_od),
    .phase(b_phase), .active_count(b_ac), .done(b_done));

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: mask array, expected-output queue, per-phase counts
  bit mask_m[N];
  bit m_phase, lat_pend, stall_pend;
  int m_fidx, m_gin, m_out, m_active, prev_data, done_cnt;
  int exp_q[$];
  int out_log[$];

  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0; m_fidx = 0; m_gin = 0; m_out = 0; m_active = 0;
      lat_pend = 0; stall_pend = 0;
      exp_q.delete();
    end else begin
      bit ph;
      int d;
      ph = m_phase;
      chk("phase", phase, ph);
      if (ph) begin
        chk("fwd_ready_bwd", fwd_ready, 0);
        chk("grad_in_ready_bwd", grad_in_ready, (m_gin < N) && (!grad_out_valid || grad_out_ready));
        chk("active_count", active_count, m_active);
      end else begin
        chk("fwd_ready_cap", fwd_ready, 1);
        chk("grad_in_ready_cap", grad_in_ready, 0);
        chk("grad_out_valid_cap", grad_out_valid, 0);
      end
      if (lat_pend) chk("latency_valid", grad_out_valid, 1);
      if (stall_pend) begin
        chk("stall_valid", grad_out_valid, 1);
        chk("stall_data", grad_out_data, prev_data);
      end
      if (grad_out_valid && grad_out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          d = exp_q.pop_front();
          chk("grad_out_data", grad_out_data, d);
        end
        out_log.push_back(int'(grad_out_data));
        chk("done", done, m_out == N - 1);
        m_out++;
        if (m_out == N) begin m_out = 0; m_phase = 0; end
      end else begin
        chk("done_idle", done, 0);
      end
      if (done) done_cnt++;
      lat_pend = 0;
      if (!ph && fwd_valid && fwd_ready) begin
        mask_m[m_fidx] = (fwd_data > 0);
        if (m_fidx == 0) m_active = 0;
        m_active += int'(fwd_data > 0);
        m_fidx++;
        if (m_fidx == N) begin m_fidx = 0; m_phase = 1; m_gin = 0; m_out = 0; end
      end
      if (ph && grad_in_valid && grad_in_ready) begin
        exp_q.push_back(mask_m[m_gin] ? int'(grad_in_data) : 0);
        m_gin++;
        lat_pend = 1;
      end
      stall_pend = grad_out_valid && !grad_out_ready;
      prev_data  = int'(grad_out_data);
    end
  end

  // downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random
  int rdy_mode = 0, rc = 0, gaps = 0;
  initial begin
    grad_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rc++;
      case (rdy_mode)
        0:       grad_out_ready = 1'b1;
        1:       grad_out_ready = (rc % 4 == 0) || (rc % 4 == 3);
        default: grad_out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // all send tasks are entered and leave at posedge+1
  task automatic send_fwd(input int v);
    int t = 0;
    if (gaps != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    fwd_valid = 1'b1; fwd_data = DW'(v);
    @(negedge clk);
    while (!fwd_ready && t < 50) begin @(negedge clk); t++; end
    if (!fwd_ready) chk("fwd_timeout", 0, 1);
    @(posedge clk); #1;
    fwd_valid = 1'b0;
  endtask

  task automatic send_grad(input int v);
    int t = 0;
    grad_in_valid = 1'b0;
    if (gaps != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    grad_in_valid = 1'b1; grad_in_data = DW'(v);
    @(negedge clk);
    while (!grad_in_ready && t < 50) begin @(negedge clk); t++; end
    if (!grad_in_ready) chk("grad_timeout", 0, 1);
    @(posedge clk); #1;
    grad_in_valid = 1'b0;
  endtask

  task automatic run_tensor(input int f[N], input int g[N]);
    int t = 0;
    for (int i = 0; i < N; i++) send_fwd(f[i]);
    for (int i = 0; i < N; i++) send_grad(g[i]);
    while (m_phase && t < 300) begin @(posedge clk); t++; end
    if (m_phase) chk("tensor_timeout", 0, 1);
    #1;
  endtask

  task automatic chk_log(input string nm, input int e[N]);
    chk({nm, "_count"}, out_log.size(), N);
    for (int i = 0; i < N && i < out_log.size(); i++) chk(nm, out_log[i], e[i]);
  endtask

  initial begin
    int d0;
    int f[N];
    int g[N];
    rst = 1'b1;
    fwd_valid = 0; fwd_data = 0; grad_in_valid = 0; grad_in_data = 0;
    b_fv = 0; b_fd = 0; b_gv = 0; b_gd = 0; b_or = 1'b1;
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase", phase, 0);
    chk("rst_gov", grad_out_valid, 0);
    chk("rst_data", grad_out_data, 0);
    chk("rst_active", active_count, 0);
    chk("rst_done", done, 0);
    chk("rst_fwd_ready", fwd_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // channel-major ordering on the 2x1x1 instance
    b_fv = 1; b_fd = 4;
    @(posedge clk); #1; b_fd = -4;
    @(posedge clk); #1; b_fv = 0; b_gv = 1; b_gd = 7;
    chk("u1_phase_bwd", b_phase, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("u1_out0", b_od, 7); chk("u1_out0_valid", b_ov, 1); chk("u1_done0", b_done, 0);
    @(posedge clk); #1; b_gv = 0;
    @(negedge clk);
    chk("u1_out1", b_od, 0); chk("u1_done1", b_done, 1);
    @(posedge clk); #1;
    chk("u1_phase_cap", b_phase, 0); chk("u1_active", b_ac, 1); chk("u1_gov_clr", b_ov, 0);

    // worked example, always-ready then stalling downstream
    out_log.delete(); d0 = done_cnt;
    run_tensor('{-3, 0, 5, 127}, '{10, -20, 30, -40});
    chk_log("t1_out", '{0, 0, 30, -40});
    chk("t1_active", active_count, 2);
    chk("t1_phase", phase, 0);
    chk("t1_done_cnt", done_cnt - d0, 1);

    rdy_mode = 1;
    out_log.delete();
    run_tensor('{-3, 0, 5, 127}, '{10, -20, 30, -40});
    chk_log("t2_out", '{0, 0, 30, -40});
    rdy_mode = 0;

    // most-negative value and zero boundaries
    out_log.delete();
    run_tensor('{-128, 1, -1, 0}, '{-128, -128, -128, -128});
    chk_log("t3_out", '{0, -128, 0, 0});
    chk("t3_active", active_count, 1);

    // async reset in the middle of BACKWARD
    for (int i = 0; i < N; i++) send_fwd(i + 1);
    for (int i = 0; i < 3; i++) send_grad(i + 1);
    chk("pre_rst_outs", m_out, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_gov", grad_out_valid, 0);
    chk("arst_data", grad_out_data, 0);
    chk("arst_phase", phase, 0);
    chk("arst_active", active_count, 0);
    chk("arst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    out_log.delete(); d0 = done_cnt;
    run_tensor('{1, 2, -3, 4}, '{5, 6, 7, 8});
    chk_log("t4_out", '{5, 6, 0, 8});
    chk("t4_active", active_count, 3);
    chk("t4_done_cnt", done_cnt - d0, 1);

    // back-to-back random tensors, gradient valid held during CAPTURE
    rdy_mode = 2; gaps = 1; d0 = done_cnt;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) begin
        f[i] = $signed(8'($urandom));
        g[i] = $signed(8'($urandom));
      end
      grad_in_valid = 1'b1; grad_in_data = DW'($urandom);
      run_tensor(f, g);
    end
    chk("rand_done_cnt", done_cnt - d0, 20);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/relu_backward_stream.md
Name: relu_backward_stream

Overview:
- Backward-pass counterpart of the combinational ReLU activation: gates a streamed gradient tensor with the derivative mask of the matching forward activation.
- Two phases per tensor. CAPTURE streams in the forward pre-activation values and stores one mask bit per element. BACKWARD streams in upstream gradients and emits gradient×mask.
- Sits between the loss/next-layer gradient path and the preceding conv/FC layer's backward engine.

Parameters:
- channels, 1, tensor channel count.
- rows, 1, tensor row count.
- cols, 1, tensor column count.
- data_size, 8, signed element width for both activation and gradient.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous and active-high.
- fwd_valid  input  1  forward element valid.
- fwd_ready  output  1  forward element accepted when fwd_valid && fwd_ready.
- fwd_data  input  data_size  signed forward pre-activation element.
- grad_in_valid  input  1  upstream gradient valid.
- grad_in_ready  output  1  upstream gradient accepted when grad_in_valid && grad_in_ready.
- grad_in_data  input  data_size  signed upstream gradient.
- grad_out_valid  output  1  gated gradient valid.
- grad_out_ready  input  1  downstream accepts when grad_out_valid && grad_out_ready.
- grad_out_data  output  data_size  signed gated gradient.
- phase  output  1  0 = CAPTURE, 1 = BACKWARD.
- active_count  output  $clog2(N+1)  number of set mask bits for the current tensor.
- done  output  1  one-cycle pulse when the last gradient of a tensor is accepted downstream.

Behaviour:
- N = channels*rows*cols. Element order is flattened channel-major, then row, then col; index = (c*rows + r)*cols + k. Both phases use the same order.
- Storage: N-bit mask register array and a 1-entry output register. Counters are max($clog2(N),1) bits wide.
- Reset (async, rst=1): state=CAPTURE, fwd_cnt=0, grad_cnt=0, out_cnt=0, grad_out_valid=0, grad_out_data=0, active_count=0, done=0. Mask contents are don't-care. Reset mid-tensor abandons the tensor.
- CAPTURE:
  - fwd_ready=1, grad_in_ready=0.
  - On each accept: mask[fwd_cnt] = (fwd_data > 0) as a signed compare, so zero and negative values give 0. active_count increments when the bit is 1. fwd_cnt increments.
  - The accept at fwd_cnt==N-1 wraps fwd_cnt to 0 and moves to BACKWARD on the next cycle.
  - active_count clears to 0 on the first accept of a new tensor (fwd_cnt==0). It holds its value through BACKWARD and after done.
- BACKWARD:
  - fwd_ready=0.
  - grad_in_ready = !grad_out_valid || grad_out_ready (pass-through pipeline register, full throughput of 1 element/cycle).
  - On grad_in accept: grad_out_data <= mask[grad_cnt] ? grad_in_data : 0, grad_out_valid <= 1, grad_cnt++. Latency is exactly 1 cycle from accept to grad_out_valid.
  - grad_out_data and grad_out_valid are held stable while grad_out_valid && !grad_out_ready.
  - A simultaneous downstream accept and upstream accept in one cycle loads the new element with no bubble. A downstream accept with no upstream accept clears grad_out_valid.
  - grad_in_ready=0 once grad_cnt has wrapped (N gradients accepted) and the last element is still pending.
  - On the downstream accept of element N-1: done=1 for that cycle, out_cnt wraps to 0, and the state returns to CAPTURE on the next cycle. fwd_ready=1 in that next cycle.
- No arithmetic beyond masking. Output width equals input width, with no saturation required. The value -2^(data_size-1) passes through unchanged when the mask bit is 1.
- Input valids asserted in the wrong phase are ignored, not accepted.
- N=1: capture and backward each take a single element; a counter width of 1 is legal.

Test Plan:
- channels=1, rows=2, cols=2. fwd -3,0,5,127 then grad 10,-20,30,-40 with grad_out_ready=1 -> grad_out 0,0,30,-40 each 1 cycle after accept; active_count=2; done pulses on the 4th output; phase returns to 0.
- Same tensor with grad_out_ready toggling 1,0,0,1,… -> no element lost or duplicated, grad_out_data stable while stalled, grad_in_ready=0 only while the register is full and stalled.
- fwd -128,1,-1,0 with grad -128 on all elements -> outputs 0,-128,0,0; active_count=1.
- Assert rst during BACKWARD after 2 outputs -> all outputs 0 immediately (async), phase=0; a fresh tensor then completes correctly with active_count recomputed.
- Back-to-back tensors with grad_in_valid held high during CAPTURE -> no grad accepted while phase=0; second tensor's mask fully overrides the first; done pulses once per tensor.
- channels=2, rows=1, cols=1, fwd 4,-4, grad 7,7 -> outputs 7,0, confirming channel-major ordering.
